// File: rtl/usb_pkg.sv
// Shared USB packet constants and decode helpers, used by both the
// receive FSM and the transmitter.
package usb_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_OUT   = 3'd1,
    PKT_IN    = 3'd2,
    PKT_DATA0 = 3'd3,
    PKT_DATA1 = 3'd4,
    PKT_ACK   = 3'd5,
    PKT_NAK   = 3'd6
  } rx_pkt_e;

  typedef enum logic [3:0] {
    IDLE, SYNC_WAIT, PID_WAIT, TOKEN1, TOKEN2, TOKEN_EOP,
    HS_EOP, DATA_RX, CHECK, DONE, ERR_WAIT
  } rx_state_e;

  // PKT_NONE covers both a failed complement check and an unsupported PID.
  function automatic rx_pkt_e pid_decode(input logic [7:0] pid);
    rx_pkt_e pkt;
    pkt = PKT_NONE;
    if (pid[7:4] == ~pid[3:0]) begin
      case (pid[3:0])
        PID_OUT:   pkt = PKT_OUT;
        PID_IN:    pkt = PKT_IN;
        PID_DATA0: pkt = PKT_DATA0;
        PID_DATA1: pkt = PKT_DATA1;
        PID_ACK:   pkt = PKT_ACK;
        PID_NAK:   pkt = PKT_NAK;
        default:   pkt = PKT_NONE;
      endcase
    end
    return pkt;
  endfunction

endpackage

// File: rtl/rx_byte_hold.sv
// Two-stage byte hold: keeps the newest two bytes back so the trailing
// CRC16 never reaches the data buffer; emits the oldest byte on overflow.
module rx_byte_hold (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       push,
  input  logic [7:0] din,
  output logic       both_full,
  output logic       emit,
  output logic [7:0] emit_data
);

  logic [1:0][7:0] stg_q, stg_d;
  logic [1:0]      full_q, full_d;
  logic            emit_q, emit_d;
  logic [7:0]      emit_data_q, emit_data_d;

  always_comb begin
    stg_d       = stg_q;
    full_d      = full_q;
    emit_d      = 1'b0;
    emit_data_d = emit_data_q;
    if (clr) begin
      stg_d  = '0;
      full_d = '0;
    end else if (push) begin
      if (&full_q) begin
        emit_d      = 1'b1;
        emit_data_d = stg_q[1];
      end
      stg_d  = {stg_q[0], din};
      full_d = {full_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stg_q       <= '0;
      full_q      <= '0;
      emit_q      <= 1'b0;
      emit_data_q <= '0;
    end else begin
      stg_q       <= stg_d;
      full_q      <= full_d;
      emit_q      <= emit_d;
      emit_data_q <= emit_data_d;
    end
  end

  assign both_full = &full_q;
  assign emit      = emit_q;
  assign emit_data = emit_data_q;

endmodule

// File: rtl/rx_packet_fsm.sv
// USB receive packet FSM: SYNC/PID checking, token and handshake framing,
// DATA payload forwarding with CRC bytes held back, error reporting.
module rx_packet_fsm
  import usb_pkg::*;
#(
  parameter int MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       byte_received,
  input  logic [7:0] rx_data,
  input  logic       eop,
  input  logic       crc_ok,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       rx_transfer_active,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data,
  output logic [6:0] rx_data_size,
  output logic       clear_crc
);

  localparam logic [6:0] MAX_SZ = 7'(MAX_DATA);

  rx_state_e  state_q, state_d;
  rx_pkt_e    pkt_type_q, pkt_type_d;
  rx_pkt_e    rx_packet_q, rx_packet_d;
  logic [6:0] size_q, size_d;
  logic       err_q, err_d;
  logic       rdy_q, rdy_d;
  logic       active_q, active_d;
  logic       clear_crc_q, clear_crc_d;
  logic       eop_seen_q, eop_seen_d;
  logic       hold_clr, hold_push, hold_full;
  rx_pkt_e    pid_pkt;

  rx_byte_hold u_hold (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (hold_clr),
    .push      (hold_push),
    .din       (rx_data),
    .both_full (hold_full),
    .emit      (store_rx_packet_data),
    .emit_data (rx_packet_data)
  );

  always_comb begin
    state_d     = state_q;
    pkt_type_d  = pkt_type_q;
    rx_packet_d = rx_packet_q;
    size_d      = size_q;
    err_d       = err_q;
    eop_seen_d  = eop_seen_q;
    clear_crc_d = 1'b0;
    hold_clr    = 1'b0;
    hold_push   = 1'b0;
    pid_pkt     = pid_decode(rx_data);

    case (state_q)
      IDLE: if (d_edge) begin
        state_d     = SYNC_WAIT;
        clear_crc_d = 1'b1;
        err_d       = 1'b0;
        size_d      = '0;
        eop_seen_d  = 1'b0;
        hold_clr    = 1'b1;
      end
      SYNC_WAIT: begin
        if (eop) begin
          state_d    = ERR_WAIT;
          eop_seen_d = 1'b1;
        end else if (byte_received) begin
          state_d = (rx_data == SYNC_BYTE) ? PID_WAIT : ERR_WAIT;
        end
      end
      PID_WAIT: begin
        if (eop) begin
          state_d    = ERR_WAIT;
          eop_seen_d = 1'b1;
        end else if (byte_received) begin
          pkt_type_d = pid_pkt;
          case (pid_pkt)
            PKT_OUT, PKT_IN:     state_d = TOKEN1;
            PKT_DATA0, PKT_DATA1: state_d = DATA_RX;
            PKT_ACK, PKT_NAK:    state_d = HS_EOP;
            default:             state_d = ERR_WAIT;
          endcase
        end
      end
      TOKEN1, TOKEN2: begin
        if (eop) begin
          state_d    = ERR_WAIT;
          eop_seen_d = 1'b1;
        end else if (byte_received) begin
          state_d = (state_q == TOKEN1) ? TOKEN2 : TOKEN_EOP;
        end
      end
      TOKEN_EOP, HS_EOP: begin
        if (eop)                state_d = DONE;
        else if (byte_received) state_d = ERR_WAIT;
      end
      DATA_RX: begin
        // eop wins over a coincident byte, which is dropped.
        if (eop) begin
          state_d = CHECK;
        end else if (byte_received) begin
          if (hold_full && size_q >= MAX_SZ) begin
            state_d = ERR_WAIT;
          end else begin
            hold_push = 1'b1;
            if (hold_full) size_d = size_q + 7'd1;
          end
        end
      end
      CHECK: begin
        if (crc_ok && hold_full) begin
          state_d = DONE;
        end else begin
          state_d    = ERR_WAIT;
          eop_seen_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      ERR_WAIT: begin
        // eop may already be behind us when the error was detected.
        if (eop || eop_seen_q) begin
          state_d    = IDLE;
          eop_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE)     rx_packet_d = pkt_type_q;
    if (state_d == ERR_WAIT) err_d = 1'b1;
    rdy_d    = (state_d == DONE);
    active_d = !(state_d inside {IDLE, DONE, ERR_WAIT});
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      pkt_type_q  <= PKT_NONE;
      rx_packet_q <= PKT_NONE;
      size_q      <= '0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
      active_q    <= 1'b0;
      clear_crc_q <= 1'b0;
      eop_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_type_q  <= pkt_type_d;
      rx_packet_q <= rx_packet_d;
      size_q      <= size_d;
      err_q       <= err_d;
      rdy_q       <= rdy_d;
      active_q    <= active_d;
      clear_crc_q <= clear_crc_d;
      eop_seen_q  <= eop_seen_d;
    end
  end

  assign rx_packet          = rx_packet_q;
  assign rx_data_ready      = rdy_q;
  assign rx_error           = err_q;
  assign rx_transfer_active = active_q;
  assign rx_data_size       = size_q;
  assign clear_crc          = clear_crc_q;

endmodule
